oven_recipe_ctrl: RTL
=====================

// Module: oven_recipe_ctrl
// PURPOSE
//  Next-generation oven controller core. Supports a multi-stage bake recipe of up to STAGES
//  (temperature, time) pairs entered with two active-low keys and a step-select switch bank.
//  Runs a preheat/bake sequence per stage with bang-bang heat control and a 1 s countdown.
//  Feeds the display and thermal-model blocks; replaces the single-stage setpoint logic.
// PARAMETERS
//  STAGES        4           max recipe stages (>=2); STG_W = $clog2(STAGES)+1
//  TEMP_W        10          temperature width, degrees (unsigned)
//  TIME_W        13          time width, seconds (unsigned)
//  DEFAULT_TEMP  300         initial temp setpoint of every stage
//  MIN_TEMP      65          temp setpoint floor
//  MAX_TEMP      500         temp setpoint ceiling
//  MAX_TIME      1800        time setpoint ceiling, seconds
//  TICK_DIV      50000000    clk cycles per 1 s tick
//  PREHEAT_TOL   5           |cur_temp - tgt_temp| <= TOL counts as at-temperature
// PORTS
//  clk         in   1        system clock
//  rst         in   1        synchronous active-high reset
//  pwr         in   1        power switch; low forces OFF
//  key_up_n    in   1        increase key, active low
//  key_dn_n    in   1        decrease key, active low
//  sw          in   6        step select, one-hot; others -> step 0
//  cur_temp    in   TEMP_W   measured oven temperature
//  state       out  3        OFF=0 SEL_N=1 SET_TEMP=2 SET_TIME=3 PREHEAT=4 BAKE=5 DONE=6
//  stage_idx   out  STG_W    current stage, 0-based
//  n_stages    out  STG_W    recipe stage count, 1..STAGES
//  tgt_temp    out  TEMP_W   setpoint of stage_idx (being edited or executed)
//  time_left   out  TIME_W   time setpoint while editing; remaining seconds in BAKE
//  heat        out  1        heater enable
//  preheated   out  1        at-temperature flag
//  done        out  1        level, high in DONE
//  done_pulse  out  1        1-cycle pulse on entry to DONE
// BEHAVIOUR
//  Reset (rst=1, dominates pwr): state=OFF, stage_idx=0, n_stages=1, tgt_temp=DEFAULT_TEMP,
//   time_left=0, heat=0, preheated=0, done=0, done_pulse=0; all stage RAM entries are
//   set to (DEFAULT_TEMP, 0); armed=0.
//  pwr=0 in any state: next cycle produces the reset values (pwr beats every other event).
//  Keys: one register of each key, so edges are 1 cycle late.
//   armed is set when both keys are high.
//   adjust-up: falling edge of key_up_n while key_dn_n high and armed. adjust-down mirrors it.
//   confirm: both keys low while armed; clears armed, so one chord advances exactly one step.
//  Steps (sw one-hot): bit 0..5 -> temp 5,10,25,50,100,1; time 5,10,30,60,300,1.
//   zero or >1 bits -> step 0.
//  Arithmetic saturates: temp clamps to [MIN_TEMP, MAX_TEMP]; time clamps to [0, MAX_TIME].
//   Compute in TEMP_W+1/TIME_W+1 bits so there is no wrap.
//  FSM:
//   OFF      -> SEL_N when pwr=1.
//   SEL_N    up/dn changes n_stages by 1, clamped to [1, STAGES]; confirm -> SET_TEMP, stage_idx=0.
//   SET_TEMP adjusts temp[stage_idx]; confirm -> SET_TIME.
//   SET_TIME adjusts time[stage_idx]; confirm with time=0 is ignored (state kept, armed cleared).
//            Confirm otherwise: if stage_idx<n_stages-1 then stage_idx++ and -> SET_TEMP,
//            else stage_idx=0 and -> PREHEAT.
//   PREHEAT  -> BAKE the first cycle preheated=1; load time_left=time[stage_idx]; clear prescaler.
//   BAKE     on each tick time_left--. A tick at time_left==1 ends the stage (time_left=0).
//            Not last stage: stage_idx++ and -> PREHEAT. Last stage: -> DONE, done_pulse=1.
//   DONE     heat=0, done=1; held until pwr=0. Keys are ignored in PREHEAT/BAKE/DONE.
//  heat = (state in PREHEAT/BAKE) && cur_temp < tgt_temp, registered (1-cycle lag).
//  preheated = |cur_temp - tgt_temp| <= PREHEAT_TOL in PREHEAT/BAKE, else 0.
//   Cooling to a lower next-stage setpoint also qualifies.
//  Tick: prescaler counts 0..TICK_DIV-1 in BAKE only. First tick comes TICK_DIV cycles after BAKE entry.
// TESTING (TICK_DIV=4, STAGES=2)
//  rst, pwr=1, chord, sw=000100, up x2, chord -> state SET_TIME, tgt_temp=350.
//  SET_TEMP at 490, sw=010000, up -> tgt_temp=500; sw=000011, down -> tgt_temp unchanged.
//  SET_TIME time=0, chord -> stays SET_TIME; chord held 10 cycles -> advances at most one state.
//  n_stages=2, (350,2),(200,1); cur_temp=346 -> PREHEAT->BAKE; 8 cycles -> stage 1, PREHEAT, heat=0.
//  Stage 1 cur_temp=200, 4 cycles -> DONE, done_pulse for 1 cycle, done=1, heat=0.
//  pwr=0 mid-BAKE -> next cycle state=OFF, time_left=0, tgt_temp=300; rst during pwr=1 -> same.

Source files
------------

// File: rtl/oven_recipe_ctrl.sv
// oven_recipe_ctrl
//   Multi-stage bake recipe controller. The operator picks a stage count, then
//   enters a (temperature, time) pair per stage using two active-low keys and
//   a one-hot step-select bank. The controller then runs PREHEAT/BAKE for
//   each stage in order, with bang-bang heater control and a 1 s countdown.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   pwr               power switch; low returns everything to reset values
//   key_up_n/key_dn_n increase / decrease keys, active low
//   sw[5:0]           one-hot step select (anything else means step 0)
//   cur_temp          measured oven temperature
//   state             FSM state: OFF=0 SEL_N=1 SET_TEMP=2 SET_TIME=3
//                     PREHEAT=4 BAKE=5 DONE=6
//   stage_idx         current stage (0-based); n_stages: recipe length
//   tgt_temp          setpoint of stage_idx
//   time_left         time setpoint while editing, remaining seconds in BAKE
//   heat              heater enable (registered)
//   preheated         at-temperature flag (registered)
//   done/done_pulse   level in DONE / single-cycle pulse on entry to DONE
//
// Key handshake: each key is registered once. An adjust fires on the falling
// edge of one key while the other is released and the unit is armed. A
// confirm fires when both keys are low while armed, and disarms; re-arming
// needs both keys released, so one held chord advances exactly one step.
module oven_recipe_ctrl #(
    parameter int STAGES       = 4,
    parameter int TEMP_W       = 10,
    parameter int TIME_W       = 13,
    parameter int DEFAULT_TEMP = 300,
    parameter int MIN_TEMP     = 65,
    parameter int MAX_TEMP     = 500,
    parameter int MAX_TIME     = 1800,
    parameter int TICK_DIV     = 50000000,
    parameter int PREHEAT_TOL  = 5,
    localparam int STG_W       = $clog2(STAGES) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwr,
    input  logic              key_up_n,
    input  logic              key_dn_n,
    input  logic [5:0]        sw,
    input  logic [TEMP_W-1:0] cur_temp,
    output logic [2:0]        state,
    output logic [STG_W-1:0]  stage_idx,
    output logic [STG_W-1:0]  n_stages,
    output logic [TEMP_W-1:0] tgt_temp,
    output logic [TIME_W-1:0] time_left,
    output logic              heat,
    output logic              preheated,
    output logic              done,
    output logic              done_pulse
);

    localparam int IDX_W = $clog2(STAGES);
    localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_SEL_N    = 3'd1,
        S_SET_TEMP = 3'd2,
        S_SET_TIME = 3'd3,
        S_PREHEAT  = 3'd4,
        S_BAKE     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t            state_q;
    logic [TEMP_W-1:0] temp_mem [STAGES];
    logic [TIME_W-1:0] time_mem [STAGES];
    logic [TIME_W-1:0] bake_left;
    logic [PS_W-1:0]   presc;
    logic              up_q, dn_q, armed;

    logic [IDX_W-1:0]  idx;
    logic [TEMP_W-1:0] cur_t, temp_step, temp_up, temp_dn;
    logic [TIME_W-1:0] cur_tm, time_step, time_up, time_dn;
    logic [TEMP_W:0]   temp_sum, temp_floor;
    logic [TIME_W:0]   time_sum;
    logic [TEMP_W-1:0] temp_diff;
    logic              adj_up, adj_dn, confirm, in_run, at_temp, stage_last, tick;

    assign idx    = stage_idx[IDX_W-1:0];
    assign cur_t  = temp_mem[idx];
    assign cur_tm = time_mem[idx];

    // Step size from the switch bank; only a clean one-hot pattern counts.
    always_comb begin
        temp_step = '0;
        time_step = '0;
        case (sw)
            6'b000001: begin temp_step = TEMP_W'(5);   time_step = TIME_W'(5);   end
            6'b000010: begin temp_step = TEMP_W'(10);  time_step = TIME_W'(10);  end
            6'b000100: begin temp_step = TEMP_W'(25);  time_step = TIME_W'(30);  end
            6'b001000: begin temp_step = TEMP_W'(50);  time_step = TIME_W'(60);  end
            6'b010000: begin temp_step = TEMP_W'(100); time_step = TIME_W'(300); end
            6'b100000: begin temp_step = TEMP_W'(1);   time_step = TIME_W'(1);   end
            default:   begin temp_step = '0;           time_step = '0;           end
        endcase
    end

    // Saturating arithmetic carried one bit wider so nothing wraps.
    always_comb begin
        temp_sum   = {1'b0, cur_t} + {1'b0, temp_step};
        temp_floor = {1'b0, temp_step} + (TEMP_W+1)'(MIN_TEMP);
        temp_up    = (temp_sum > (TEMP_W+1)'(MAX_TEMP)) ? TEMP_W'(MAX_TEMP) : temp_sum[TEMP_W-1:0];
        temp_dn    = ({1'b0, cur_t} < temp_floor) ? TEMP_W'(MIN_TEMP) : cur_t - temp_step;
        time_sum   = {1'b0, cur_tm} + {1'b0, time_step};
        time_up    = (time_sum > (TIME_W+1)'(MAX_TIME)) ? TIME_W'(MAX_TIME) : time_sum[TIME_W-1:0];
        time_dn    = (cur_tm < time_step) ? '0 : cur_tm - time_step;
    end

    assign adj_up     = armed && up_q && !key_up_n && key_dn_n;
    assign adj_dn     = armed && dn_q && !key_dn_n && key_up_n;
    assign confirm    = armed && !key_up_n && !key_dn_n;
    assign in_run     = (state_q == S_PREHEAT) || (state_q == S_BAKE);
    assign temp_diff  = (cur_temp >= cur_t) ? cur_temp - cur_t : cur_t - cur_temp;
    assign at_temp    = (temp_diff <= TEMP_W'(PREHEAT_TOL));
    assign stage_last = (stage_idx == n_stages - STG_W'(1));
    assign tick       = (presc == PS_MAX);

    always_ff @(posedge clk) begin
        if (rst || !pwr) begin
            state_q    <= S_OFF;
            stage_idx  <= '0;
            n_stages   <= STG_W'(1);
            bake_left  <= '0;
            presc      <= '0;
            heat       <= 1'b0;
            preheated  <= 1'b0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
            armed      <= 1'b0;
            up_q       <= 1'b1;
            dn_q       <= 1'b1;
            for (int i = 0; i < STAGES; i++) begin
                temp_mem[i] <= TEMP_W'(DEFAULT_TEMP);
                time_mem[i] <= '0;
            end
        end else begin
            up_q       <= key_up_n;
            dn_q       <= key_dn_n;
            done_pulse <= 1'b0;
            heat       <= in_run && (cur_temp < cur_t);
            preheated  <= in_run && at_temp;
            if (key_up_n && key_dn_n) armed <= 1'b1;
            else if (confirm)         armed <= 1'b0;

            case (state_q)
                S_OFF: state_q <= S_SEL_N;
                S_SEL_N: begin
                    if (confirm) begin
                        state_q   <= S_SET_TEMP;
                        stage_idx <= '0;
                    end else if (adj_up && n_stages < STG_W'(STAGES)) begin
                        n_stages <= n_stages + STG_W'(1);
                    end else if (adj_dn && n_stages > STG_W'(1)) begin
                        n_stages <= n_stages - STG_W'(1);
                    end
                end
                S_SET_TEMP: begin
                    if (confirm)     state_q       <= S_SET_TIME;
                    else if (adj_up) temp_mem[idx] <= temp_up;
                    else if (adj_dn) temp_mem[idx] <= temp_dn;
                end
                S_SET_TIME: begin
                    // A zero-length stage cannot be confirmed; the chord is
                    // still consumed (armed drops above).
                    if (confirm) begin
                        if (cur_tm != '0) begin
                            if (!stage_last) begin
                                stage_idx <= stage_idx + STG_W'(1);
                                state_q   <= S_SET_TEMP;
                            end else begin
                                stage_idx <= '0;
                                state_q   <= S_PREHEAT;
                            end
                        end
                    end else if (adj_up) begin
                        time_mem[idx] <= time_up;
                    end else if (adj_dn) begin
                        time_mem[idx] <= time_dn;
                    end
                end
                S_PREHEAT: begin
                    if (preheated) begin
                        state_q   <= S_BAKE;
                        bake_left <= cur_tm;
                        presc     <= '0;
                    end
                end
                S_BAKE: begin
                    if (tick) begin
                        presc <= '0;
                        if (bake_left <= TIME_W'(1)) begin
                            bake_left <= '0;
                            // The flag was judged against the old setpoint.
                            preheated <= 1'b0;
                            if (!stage_last) begin
                                stage_idx <= stage_idx + STG_W'(1);
                                state_q   <= S_PREHEAT;
                            end else begin
                                state_q    <= S_DONE;
                                done       <= 1'b1;
                                done_pulse <= 1'b1;
                                heat       <= 1'b0;
                            end
                        end else begin
                            bake_left <= bake_left - TIME_W'(1);
                        end
                    end else begin
                        presc <= presc + PS_W'(1);
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    heat <= 1'b0;
                end
                default: state_q <= S_OFF;
            endcase
        end
    end

    assign state     = state_q;
    assign tgt_temp  = cur_t;
    assign time_left = (state_q == S_SET_TEMP || state_q == S_SET_TIME) ? cur_tm : bake_left;

endmodule
